user_io_term_bridge: RTL and testbench
======================================

Name: user_io_term_bridge

Overview:
- Parametrised successor to the fixed 20-channel top-edge user-project IO BEL.
- Bridges NUM_CH user-project pins and fabric switch-matrix wires.
- Each channel's direction is independently programmed as bypass, registered, synchronised or edge-pulse.
- Per-channel config is latched from the frame config bus; the block also forwards FrameStrobe and UserCLK like a terminal tile.

Parameters:
NUM_CH, 20, number of IO channels (1..64)
SYNC_STAGES, 2, synchroniser depth for modes 10/11 (>=2)
FILTER_LEN, 4, consecutive stable cycles required by glitch filter (>=1; used only with macro)
FrameBitsPerRow, 32, FrameData width
MaxFramesPerCol, 20, FrameStrobe width
CFG_FRAME, 0, first FrameStrobe index carrying this block's config

Ports:
UserCLK  input  1  fabric user clock, rising edge
Reset  input  1  asynchronous active-high reset
UIN  input  NUM_CH  user-project to fabric pins
FIN  output  NUM_CH  to switch matrix (conditioned UIN)
FOUT  input  NUM_CH  from switch matrix
UOUT  output  NUM_CH  to user project (conditioned FOUT)
FrameData  input  FrameBitsPerRow  config data
FrameStrobe  input  MaxFramesPerCol  config frame strobes
FrameStrobe_O  output  MaxFramesPerCol  buffered copy of FrameStrobe (combinational)
UserCLKo  output  1  buffered copy of UserCLK

Behaviour:
- Config register CFG, width 3*NUM_CH:
  - CFG[2c+1:2c] = input mode of channel c.
  - CFG[2*NUM_CH+c] = output-register enable of channel c.
- Config frames: NCF = ceil(3*NUM_CH/FrameBitsPerRow). Elaboration error if CFG_FRAME+NCF > MaxFramesPerCol.
- Config load: on each UserCLK rising edge with FrameStrobe[CFG_FRAME+k] high, CFG[k*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData.
  - The last frame is truncated; excess FrameData bits are ignored.
  - Several strobes high at once each load their own slice.
  - A strobe held for several cycles reloads every cycle (idempotent).
- Reset (async): CFG=0, all sync/prev/output flops=0. With CFG=0, every channel is bypass, so FIN=UIN and UOUT=FOUT combinationally (legacy-equivalent).
- Input modes, per channel:
  - 00 bypass: FIN=UIN, 0 latency.
  - 01 registered: FIN = UIN sampled one edge earlier.
  - 10 sync: FIN = s[SYNC_STAGES-1] of the synchroniser chain; UIN change appears after SYNC_STAGES edges.
  - 11 pulse: FIN = s_last & ~prev, where prev is s_last delayed one edge. FIN is high for exactly one cycle, starting SYNC_STAGES edges after a UIN rise. Falling edges and held-high input produce nothing.
- Synchroniser, prev and registered-mode flops run continuously in every mode. A mode change therefore takes effect on the next edge with no reset of history.
- Output path: UOUT[c] = out-reg enable ? FOUT[c] registered one edge : FOUT[c] combinational.
- FrameStrobe_O and UserCLKo are pure buffers, independent of Reset.
- Reset asserted mid-operation: all outputs revert immediately to bypass values; in-flight pulses are dropped. Deassertion needs no synchronous release beyond the async clear.

Optional Feature:
USER_IO_GLITCH_FILTER_EN
- Defined: per-channel counter (width clog2(FILTER_LEN+1)) plus filtered value f, both reset to 0.
  - The counter increments while s_last != f and clears when they are equal.
  - When the counter would reach FILTER_LEN, f <= s_last and the counter clears.
  - Modes 10 and 11 use f in place of s_last, adding FILTER_LEN edges of latency.
- Undefined: no counters exist, FILTER_LEN is ignored, and modes 10/11 behave exactly as above.

Test Plan:
1. Reset high, UIN=0x5A5A5, FOUT=0xFFFFF -> FIN=0x5A5A5, UOUT=0xFFFFF with no clock edges.
2. FrameStrobe[0]=1 for one edge with FrameData=0x00000009 (ch0 mode 01, ch1 mode 10); raise UIN0 and UIN1 together -> FIN0 rises at edge 1, FIN1 rises at edge 2.
3. FrameData=0x00000030 on strobe 0 (ch2 mode 11); hold UIN2 high for 10 cycles -> FIN2=1 only between edges 2 and 3; no further pulse; falling UIN2 gives no pulse.
4. FrameStrobe[1]=1 with FrameData=0x00000100 (CFG bit 40, ch0 out-reg); toggle FOUT0 each cycle -> UOUT0 equals FOUT0 delayed one edge; other UOUT bits remain combinational.
5. Ch1 in mode 10 with FIN1=1; assert Reset between edges, UIN1=0 -> FIN1=0 immediately, CFG reads as all-zero (bypass) after release.
6. With USER_IO_GLITCH_FILTER_EN and FILTER_LEN=4, ch1 mode 10:
   - 2-cycle high glitch on UIN1 -> FIN1 stays 0.
   - 8-cycle high on UIN1 -> FIN1 rises at edge 6 after the UIN1 rise.

Source files
------------

// File: rtl/user_io_term_bridge_if.sv
// Pin bundle between the user project and the fabric switch matrix.
// No logic; master drives UIN/FOUT, slave (the bridge) drives FIN/UOUT.
// Widths follow NUM_CH of the instantiating bridge.
interface user_io_term_bridge_if #(
   parameter int NUM_CH = 20
);
   logic [NUM_CH-1:0] UIN;
   logic [NUM_CH-1:0] FIN;
   logic [NUM_CH-1:0] FOUT;
   logic [NUM_CH-1:0] UOUT;

   modport master (output UIN, output FOUT, input FIN, input UOUT);
   modport slave  (input UIN, input FOUT, output FIN, output UOUT);
endinterface

// File: rtl/user_io_term_bridge.sv
// Top-edge user IO terminal bridge: per-channel bypass/registered/sync/pulse
// input conditioning and optional output register, configured from frame bus.
// Latency 0 (bypass) to SYNC_STAGES(+FILTER_LEN) edges; no backpressure.
// Optional glitch filter on sync/pulse modes: define USER_IO_GLITCH_FILTER_EN.
module user_io_term_bridge #(
   parameter int NUM_CH          = 20,
   parameter int SYNC_STAGES     = 2,
   parameter int FILTER_LEN      = 4,
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20,
   parameter int CFG_FRAME       = 0
) (
   input  logic                       UserCLK,
   input  logic                       Reset,
   user_io_term_bridge_if.slave       io,
   input  logic [FrameBitsPerRow-1:0] FrameData,
   input  logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
   output logic                       UserCLKo
);
   localparam int CFG_W = 3 * NUM_CH;
   localparam int NCF   = (CFG_W + FrameBitsPerRow - 1) / FrameBitsPerRow;

   // Parameter sanity checks at elaboration
   if (CFG_FRAME + NCF > MaxFramesPerCol) begin : g_err_frames
      $error("user_io_term_bridge: config frames exceed MaxFramesPerCol");
   end
   if (NUM_CH < 1 || NUM_CH > 64) begin : g_err_numch
      $error("user_io_term_bridge: NUM_CH must be 1..64");
   end
   if (SYNC_STAGES < 2) begin : g_err_sync
      $error("user_io_term_bridge: SYNC_STAGES must be >= 2");
   end
   if (FILTER_LEN < 1) begin : g_err_filt
      $error("user_io_term_bridge: FILTER_LEN must be >= 1");
   end

   logic [CFG_W-1:0]                    cfg_q, cfg_d;
   logic [CFG_W-1:0]                    cfg_ld, cfg_wd;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q;
   logic [NUM_CH-1:0]                   reg_q, prev_q, uout_q;
   logic [NUM_CH-1:0]                   s_last, cond, pulse;
   logic [NUM_CH-1:0]                   m_lo, m_hi, oen;

   // Terminal-tile pass-through, independent of reset
   assign FrameStrobe_O = FrameStrobe;
   assign UserCLKo      = UserCLK;

   // Each config bit knows which strobe loads it and which FrameData bit feeds it;
   // bits past CFG_W in the last frame simply have no destination.
   for (genvar gi = 0; gi < CFG_W; gi++) begin : g_cfgmap
      assign cfg_ld[gi] = FrameStrobe[CFG_FRAME + gi / FrameBitsPerRow];
      assign cfg_wd[gi] = FrameData[gi % FrameBitsPerRow];
   end

   assign cfg_d = (cfg_q & ~cfg_ld) | (cfg_wd & cfg_ld);

   // Unpack per-channel mode and output-register enable
   for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_mode
      assign m_lo[gc] = cfg_q[2*gc];
      assign m_hi[gc] = cfg_q[2*gc+1];
   end
   assign oen    = cfg_q[CFG_W-1:2*NUM_CH];
   assign s_last = sync_q[SYNC_STAGES-1];

`ifdef USER_IO_GLITCH_FILTER_EN
   localparam int CW = $clog2(FILTER_LEN + 1);

   for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_filt
      logic [CW-1:0] cnt_q, cnt_d;
      logic          f_q, f_d;

      // Count consecutive disagreeing cycles; adopt s_last once it has held FILTER_LEN edges
      always_comb begin
         cnt_d = '0;
         f_d   = f_q;
         if (s_last[gc] != f_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
               f_d = s_last[gc];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // Filter state, cleared by async reset
      always_ff @(posedge UserCLK or posedge Reset) begin
         if (Reset) begin
            cnt_q <= '0;
            f_q   <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            f_q   <= f_d;
         end
      end

      assign cond[gc] = f_q;
   end
`else
   assign cond = s_last;
`endif

   assign pulse = cond & ~prev_q;

   // Per-channel input mode select; cfg=0 gives pure bypass
   assign io.FIN = (~m_hi & ~m_lo & io.UIN)
                 | (~m_hi &  m_lo & reg_q)
                 | ( m_hi & ~m_lo & cond)
                 | ( m_hi &  m_lo & pulse);

   assign io.UOUT = (oen & uout_q) | (~oen & io.FOUT);

   // Config and conditioning history; history flops run in every mode so a
   // mode switch takes effect on the next edge without a restart
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         cfg_q  <= '0;
         sync_q <= '0;
         reg_q  <= '0;
         prev_q <= '0;
         uout_q <= '0;
      end else begin
         cfg_q  <= cfg_d;
         sync_q <= {sync_q[SYNC_STAGES-2:0], io.UIN};
         reg_q  <= io.UIN;
         prev_q <= cond;
         uout_q <= io.FOUT;
      end
   end
endmodule

// File: tb/tb_user_io_term_bridge.sv
// Directed bench for user_io_term_bridge with default parameters.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Filter scenario runs only when USER_IO_GLITCH_FILTER_EN is defined.
module tb_user_io_term_bridge;
   localparam int N = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fdata;
   logic [19:0] fstrobe;
   logic [19:0] fstrobe_o;
   logic        clk_o;
   int          checks = 0;
   int          failures = 0;
   logic        last_u0;

   user_io_term_bridge_if #(.NUM_CH(N)) io ();

   user_io_term_bridge dut (
      .UserCLK      (clk),
      .Reset        (rst),
      .io           (io),
      .FrameData    (fdata),
      .FrameStrobe  (fstrobe),
      .FrameStrobe_O(fstrobe_o),
      .UserCLKo     (clk_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1: reset, bypass, buffers
      rst = 1'b1; fdata = '0; fstrobe = '0;
      io.UIN = 20'h5A5A5; io.FOUT = 20'hFFFFF;
      #3;
      chk("rst_fin", 64'(io.FIN), 64'h5A5A5);
      chk("rst_uout", 64'(io.UOUT), 64'hFFFFF);
      fstrobe = 20'hA5A5A;
      #1;
      chk("strobe_buf", 64'(fstrobe_o), 64'hA5A5A);
      chk("clk_buf", 64'(clk_o), 64'(clk));
      fstrobe = '0;
      rst = 1'b0; io.UIN = '0; io.FOUT = '0;
      repeat (3) tick();

      // 2: ch0 registered, ch1 sync
      fdata = 32'h9; fstrobe = 20'h1;
      tick();
      fstrobe = '0;
      io.UIN = 20'h3;
      #1;
      chk("t2_e0", 64'(io.FIN[1:0]), 64'h0);
      tick();
      chk("t2_e1", 64'(io.FIN[1:0]), 64'h1);
      tick();
      chk("t2_e2", 64'(io.FIN[1:0]), 64'h3);

      // 3: ch2 pulse (ch0/ch1 modes kept)
      fdata = 32'h39; fstrobe = 20'h1;
      tick();
      fstrobe = '0;
      io.UIN[2] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk($sformatf("t3_hi_e%0d", i), 64'(io.FIN[2]), 64'(i == 2));
      end
      io.UIN[2] = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("t3_fall_e%0d", i), 64'(io.FIN[2]), 64'h0);
      end

      // 4: ch0 output register via frame 1
      fdata = 32'h100; fstrobe = 20'h2;
      tick();
      fstrobe = '0;
      last_u0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         io.FOUT[0] = ~io.FOUT[0];
         io.FOUT[5] = i[0];
         #1;
         chk($sformatf("t4_hold%0d", i), 64'(io.UOUT[0]), 64'(last_u0));
         chk($sformatf("t4_comb%0d", i), 64'(io.UOUT[5]), 64'(i[0]));
         tick();
         last_u0 = io.FOUT[0];
         chk($sformatf("t4_reg%0d", i), 64'(io.UOUT[0]), 64'(last_u0));
      end

      // 5: async reset mid-operation
      chk("t5_pre", 64'(io.FIN[1]), 64'h1);
      io.UIN = '0;
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_fin", 64'(io.FIN), 64'h0);
      chk("t5_rst_uout", 64'(io.UOUT), 64'(io.FOUT));
      #1 rst = 1'b0;
      #1;
      io.UIN = 20'h12345; io.FOUT = 20'hABCDE;
      #1;
      chk("t5_byp_fin", 64'(io.FIN), 64'h12345);
      chk("t5_byp_uout", 64'(io.UOUT), 64'hABCDE);
      tick();
      chk("t5_byp_fin_e", 64'(io.FIN), 64'h12345);

      // multi-strobe, held two cycles: ch0 and ch16 registered
      fdata = 32'h1; fstrobe = 20'h3;
      repeat (2) tick();
      fstrobe = '0;
      io.UIN = '0;
      #1;
      chk("ms_hold", 64'(io.FIN & 20'h10003), 64'h10001);
      tick();
      chk("ms_clear", 64'(io.FIN & 20'h10003), 64'h0);

`ifdef USER_IO_GLITCH_FILTER_EN
      // 6: glitch filter on ch1 sync mode
      fdata = 32'h8; fstrobe = 20'h1;
      tick();
      fstrobe = '0;
      repeat (5) tick();
      io.UIN[1] = 1'b1;
      repeat (2) tick();
      io.UIN[1] = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("t6_glitch%0d", i), 64'(io.FIN[1]), 64'h0);
      end
      io.UIN[1] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("t6_long_e%0d", i), 64'(io.FIN[1]), 64'(i >= 6));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
